word_serializer_32: RTL and testbench
=====================================

WORD_SERIALIZER_32 -- requirements
Module: word_serializer_32

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 0; 0 sends bit 0 first, 1 sends bit 31 first.
REQ-002 The block SHALL have parameter PARITY_EN, default 0; 1 appends one even-parity bit after the 32 data bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port din, input, 32, the parallel word to serialize.
REQ-006 The block SHALL have port load_valid, input, 1, meaning din is offered.
REQ-007 The block SHALL have port load_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 The block SHALL have port sout, output, 1, the current serial bit.
REQ-009 The block SHALL have port sout_valid, output, 1, meaning sout holds a valid bit.
REQ-010 The block SHALL have port sout_ready, input, 1, meaning downstream consumes sout this cycle.
REQ-011 The block SHALL have port last, output, 1, meaning the bit on sout is the final bit of the frame.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse after the final bit is consumed.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and PAR; PAR is reachable only when PARITY_EN=1.
REQ-014 load_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 Load acceptance: when load_valid=1 and load_ready=1 on an edge, the block SHALL capture din into a 32-bit shift register.
- The same edge SHALL compute parity = XOR of all 32 din bits, clear the 6-bit bit counter to 0, and enter SHIFT.
REQ-016 sout_valid SHALL be 1 in SHIFT and PAR and 0 in IDLE; the first bit SHALL appear the cycle after acceptance.
REQ-017 A bit transfer SHALL occur on an edge where sout_valid=1 and sout_ready=1.
- On a transfer, the shift register SHALL shift toward the output end and the counter SHALL increment.
REQ-018 While sout_valid=1 and sout_ready=0, sout, last and the counter SHALL hold unchanged.
REQ-019 In SHIFT, sout SHALL be shift-register bit 0 when MSB_FIRST=0 and bit 31 when MSB_FIRST=1.
REQ-020 On the transfer of counter value 31, the FSM SHALL go to PAR if PARITY_EN=1, otherwise to IDLE.
REQ-021 In PAR, sout SHALL equal the captured parity; on its transfer the FSM SHALL go to IDLE.
REQ-022 last SHALL be 1 only while the final bit of the frame is on sout: counter=31 in SHIFT with PARITY_EN=0, or any cycle in PAR.
REQ-023 done SHALL be registered and pulse high for exactly one cycle, the cycle after the final transfer.
REQ-024 load_valid outside IDLE SHALL be ignored, with no effect on the frame in progress.
- A word offered in the same cycle done is high SHALL be accepted, because the state is IDLE then.
REQ-025 Minimum frame time with sout_ready held at 1 SHALL be 32 cycles (33 with parity) from acceptance to return to IDLE, with no bubbles.
REQ-026 The counter SHALL never exceed 31; the block SHALL perform no wrap-around into a second frame without a new load.

Reset
REQ-027 While rst=0, the following SHALL hold regardless of clk: state IDLE, shift register 0, counter 0, parity 0, sout 0, sout_valid 0, last 0, done 0, load_ready 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; no further bits or done pulse SHALL be emitted for it.
REQ-029 After rst rises, the first accepted load SHALL start a fresh frame at bit 0.

Verification
REQ-030 MSB_FIRST=0, din=0x00000001, sout_ready=1 -> the bench SHALL check:
- sout is 1 on the first bit, then 31 zeros;
- last is high on the 32nd bit;
- done pulses on the following cycle.
REQ-031 MSB_FIRST=1, din=0x80000000 -> the bench SHALL check that the first bit is 1 and the remaining 31 bits are 0.
REQ-032 Backpressure: drop sout_ready for 3 cycles while bit 5 is on sout -> the bench SHALL check that sout, counter and last hold for those 3 cycles and that the frame still totals 32 transfers.
REQ-033 PARITY_EN=1, din=0x00000007 -> the bench SHALL check 33 transfers, a 33rd bit of 1, and last high only on the 33rd bit.
REQ-034 Busy load: offer load_valid with din=0xFFFFFFFF during SHIFT -> the bench SHALL check that load_ready is 0 and the stream matches the original word.
REQ-035 Reset after 10 transfers -> the bench SHALL check all outputs at reset values, no done pulse, and that the next load of 0xA5A5A5A5 streams from bit 0.

Source files
------------

// File: rtl/word_serializer_32.sv
// 32-bit parallel-to-serial converter with valid/ready handshakes on both sides,
// selectable bit order and an optional trailing even-parity bit.
module word_serializer_32 #(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        sout,
  output logic        sout_valid,
  input  logic        sout_ready,
  output logic        last,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] shreg;
  logic [5:0]  bit_cnt;
  logic        parity;

  // NOTE: the shift register is reset along with the control state because a
  // frame aborted by reset must leave no stale data behind for the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      parity     <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      last       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge values of shreg/bit_cnt regardless of statement order.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            state      <= SHIFT;
            shreg      <= din;
            parity     <= ^din;
            bit_cnt    <= '0;
            sout       <= MSB_FIRST ? din[31] : din[0];
            sout_valid <= 1'b1;
            last       <= 1'b0;
            load_ready <= 1'b0;
          end
        end

        SHIFT: begin
          if (sout_ready) begin
            shreg <= MSB_FIRST ? {shreg[30:0], 1'b0} : {1'b0, shreg[31:1]};
            if (bit_cnt == 6'd31) begin
              if (PARITY_EN) begin
                state <= PAR;
                sout  <= parity;
                last  <= 1'b1;
              end else begin
                state      <= IDLE;
                sout       <= 1'b0;
                sout_valid <= 1'b0;
                last       <= 1'b0;
                load_ready <= 1'b1;
                done       <= 1'b1;
              end
            end else begin
              // Counter saturates at 31; the next bit is pre-fetched one position in.
              bit_cnt <= bit_cnt + 6'd1;
              sout    <= MSB_FIRST ? shreg[30] : shreg[1];
              last    <= !PARITY_EN && (bit_cnt == 6'd30);
            end
          end
        end

        PAR: begin
          if (sout_ready) begin
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            last       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          sout_valid <= 1'b0;
          last       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer_32.sv
// Scoreboard bench for word_serializer_32: three instances cover LSB-first,
// MSB-first and parity-enabled framing; expected bit streams are queued at load.
module tb_word_serializer_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din        [3];
  logic        load_valid [3];
  logic        load_ready [3];
  logic        sout       [3];
  logic        sout_valid [3];
  logic        sout_ready [3];
  logic        last       [3];
  logic        done       [3];

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  word_serializer_32 #(.MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din[0]), .load_valid(load_valid[0]),
    .load_ready(load_ready[0]), .sout(sout[0]), .sout_valid(sout_valid[0]),
    .sout_ready(sout_ready[0]), .last(last[0]), .done(done[0])
  );

  word_serializer_32 #(.MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .din(din[1]), .load_valid(load_valid[1]),
    .load_ready(load_ready[1]), .sout(sout[1]), .sout_valid(sout_valid[1]),
    .sout_ready(sout_ready[1]), .last(last[1]), .done(done[1])
  );

  word_serializer_32 #(.MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_par (
    .clk(clk), .rst(rst), .din(din[2]), .load_valid(load_valid[2]),
    .load_ready(load_ready[2]), .sout(sout[2]), .sout_valid(sout_valid[2]),
    .sout_ready(sout_ready[2]), .last(last[2]), .done(done[2])
  );

  // Instance 1 is MSB-first, instance 2 appends parity.
  task automatic push_frame(input int idx, input logic [31:0] word);
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.b = (idx == 1) ? word[31 - i] : word[i];
      e.l = (i == 31) && (idx != 2);
      exp_q.push_back(e);
    end
    if (idx == 2) begin
      e.b = ^word;
      e.l = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic load_word(input int idx, input logic [31:0] word);
    checks++;
    if (load_ready[idx] !== 1'b1)
      $display("FAIL load_ready_idle[%0d]: got %b expected 1", idx, load_ready[idx]);
    if (load_ready[idx] !== 1'b1) errors++;
    din[idx]        = word;
    load_valid[idx] = 1'b1;
    @(negedge clk);
    load_valid[idx] = 1'b0;
    push_frame(idx, word);
  endtask

  task automatic drain(input int idx, input int stall_at, input int stall_len,
                       input bit busy, input bit chain, input logic [31:0] chain_word,
                       input int exp_xfers);
    int n      = 0;
    int stalls = 0;
    bit finished = 1'b0;
    exp_t e;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (sout_valid[idx] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_bit[%0d]: transfer %0d beyond expected frame", idx, n);
        end else begin
          e = exp_q[0];
          if ({sout[idx], last[idx]} !== {e.b, e.l}) begin
            errors++;
            $display("FAIL bit[%0d] #%0d: got sout=%b last=%b expected sout=%b last=%b",
                     idx, n, sout[idx], last[idx], e.b, e.l);
          end
        end
        checks++;
        if (done[idx] !== 1'b0) begin
          errors++;
          $display("FAIL done_early[%0d] #%0d: got %b expected 0", idx, n, done[idx]);
        end
        if (busy) begin
          load_valid[idx] = (n >= 3) && (n < 6);
          din[idx]        = 32'hFFFF_FFFF;
          if (load_valid[idx]) begin
            checks++;
            if (load_ready[idx] !== 1'b0) begin
              errors++;
              $display("FAIL busy_load_ready[%0d]: got %b expected 0", idx, load_ready[idx]);
            end
          end
        end
        if (n == stall_at && stalls < stall_len) begin
          if (idx == 0 && stalls > 0) begin
            checks++;
            if (dut_lsb.bit_cnt !== 6'(n)) begin
              errors++;
              $display("FAIL stall_counter: got %0d expected %0d", dut_lsb.bit_cnt, n);
            end
          end
          sout_ready[idx] = 1'b0;
          stalls++;
        end else begin
          sout_ready[idx] = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          n++;
        end
      end else begin
        sout_ready[idx] = 1'b0;
        load_valid[idx] = 1'b0;
        checks++;
        if (n !== exp_xfers || exp_q.size() != 0) begin
          errors++;
          $display("FAIL transfer_count[%0d]: got %0d expected %0d (left %0d)",
                   idx, n, exp_xfers, exp_q.size());
        end
        checks++;
        if (done[idx] !== 1'b1) begin
          errors++;
          $display("FAIL done_pulse[%0d]: got %b expected 1", idx, done[idx]);
        end
        if (chain) begin
          load_word(idx, chain_word);
        end else begin
          @(negedge clk);
          checks++;
          if (done[idx] !== 1'b0) begin
            errors++;
            $display("FAIL done_width[%0d]: got %b expected 0", idx, done[idx]);
          end
        end
        finished = 1'b1;
      end
      if (!finished) @(negedge clk);
    end
    if (!finished) begin
      errors++;
      checks++;
      $display("FAIL timeout[%0d]: frame did not finish, %0d transfers seen", idx, n);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({sout[i], sout_valid[i], last[i], done[i], load_ready[i]} !== 5'b00001) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b expected 00001", i,
                 {sout[i], sout_valid[i], last[i], done[i], load_ready[i]});
      end
    end
  endtask

  task automatic test_lsb_first;
    load_word(0, 32'h0000_0001);
    drain(0, -1, 0, 1'b0, 1'b0, 32'h0, 32);
  endtask

  task automatic test_msb_first;
    load_word(1, 32'h8000_0000);
    drain(1, -1, 0, 1'b0, 1'b0, 32'h0, 32);
    load_word(1, 32'h1234_ABCD);
    drain(1, -1, 0, 1'b0, 1'b0, 32'h0, 32);
  endtask

  task automatic test_backpressure;
    load_word(0, 32'h0000_0020);
    drain(0, 5, 3, 1'b0, 1'b0, 32'h0, 32);
  endtask

  task automatic test_parity;
    load_word(2, 32'h0000_0007);
    drain(2, -1, 0, 1'b0, 1'b0, 32'h0, 33);
    load_word(2, 32'hC3C3_0101);
    drain(2, 10, 2, 1'b0, 1'b0, 32'h0, 33);
  endtask

  task automatic test_busy_load;
    load_word(0, 32'h0F0F_1234);
    drain(0, -1, 0, 1'b1, 1'b0, 32'h0, 32);
  endtask

  task automatic test_back_to_back;
    load_word(0, 32'hDEAD_BEEF);
    drain(0, -1, 0, 1'b0, 1'b1, 32'h1357_9BDF, 32);
    drain(0, -1, 0, 1'b0, 1'b0, 32'h0, 32);
  endtask

  task automatic test_reset_mid_frame;
    exp_t e;
    load_word(0, 32'h3C3C_0F0F);
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (sout[0] !== e.b) begin
        errors++;
        $display("FAIL pre_abort_bit #%0d: got %b expected %b", i, sout[0], e.b);
      end
      sout_ready[0] = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({sout[0], sout_valid[0], last[0], done[0], load_ready[0]} !== 5'b00001) begin
      errors++;
      $display("FAIL abort_outputs: got %b expected 00001",
               {sout[0], sout_valid[0], last[0], done[0], load_ready[0]});
    end
    checks++;
    if (dut_lsb.bit_cnt !== 6'd0) begin
      errors++;
      $display("FAIL abort_counter: got %0d expected 0", dut_lsb.bit_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b0 || sout_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL post_abort_quiet #%0d: got done=%b sout_valid=%b expected 0 0",
                 i, done[0], sout_valid[0]);
      end
    end
    sout_ready[0] = 1'b0;
    load_word(0, 32'hA5A5_A5A5);
    drain(0, -1, 0, 1'b0, 1'b0, 32'h0, 32);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i]        = '0;
      load_valid[i] = 1'b0;
      sout_ready[i] = 1'b0;
    end
    #12;
    test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_lsb_first;
    test_msb_first;
    test_backpressure;
    test_parity;
    test_busy_load;
    test_back_to_back;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
